// File: rtl/dff_pipe_pkg.sv
// Shared constants and helpers for the dff_pipe register pipeline.
// Parity helpers are only referenced when DFF_PIPE_PARITY_EN is defined.
package dff_pipe_pkg;

  localparam int DFF_PIPE_WIDTH_DEF = 8;
  localparam int DFF_PIPE_DEPTH_DEF = 4;

  // Widest word even_par can fold; callers zero-extend, which leaves parity unchanged.
  localparam int PAR_MAX_W = 1024;

  // Bits needed to hold a count in 0..depth.
  function automatic int clog2_p1(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Even-parity bit: data plus this bit always carries an even number of ones.
  function automatic logic even_par(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline slot: valid flag plus data word, loaded when its advance enable is high.
// With DFF_PIPE_PARITY_EN defined the slot also carries an even-parity bit.
module dff_pipe_stage
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH   = DFF_PIPE_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  input  logic             up_vld,
  input  logic [WIDTH-1:0] up_data,
`ifdef DFF_PIPE_PARITY_EN
  input  logic             up_par,
  output logic             par,
`endif
  output logic             vld,
  output logic [WIDTH-1:0] data
);

  logic load;

  // Data only moves on a real word; bubbles and flushes leave it untouched.
  assign load = adv & up_vld & ~clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= 1'b0;
    end else if (clr) begin
      vld <= 1'b0;
    end else if (adv) begin
      vld <= up_vld;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data <= RST_VAL;
    end else if (load) begin
      data <= up_data;
    end
  end

`ifdef DFF_PIPE_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par <= even_par(PAR_MAX_W'(RST_VAL));
    end else if (load) begin
      par <= up_par;
    end
  end
`endif

endmodule

// File: rtl/dff_pipe.sv
// WIDTH x DEPTH register pipeline with ready/valid backpressure, bubble collapse and occupancy.
// Define DFF_PIPE_PARITY_EN to add per-stage parity with par_err / par_err_sticky outputs.
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH   = DFF_PIPE_WIDTH_DEF,
  parameter int               DEPTH   = DFF_PIPE_DEPTH_DEF,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
`ifdef DFF_PIPE_PARITY_EN
  output logic                        par_err,
  output logic                        par_err_sticky,
`endif
  output logic [clog2_p1(DEPTH)-1:0]  occ
);

  localparam int OCC_W = clog2_p1(DEPTH);

  if (DEPTH < 1) begin : g_bad_depth
    $fatal(1, "dff_pipe: DEPTH must be at least 1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "dff_pipe: WIDTH must be at least 1");
  end

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] adv;
  logic             adv_run;
  logic             in_xfer;
  logic             out_xfer;
  logic [OCC_W-1:0] occ_q;

`ifdef DFF_PIPE_PARITY_EN
  logic [DEPTH-1:0] par_q;
  logic             par_in;
  logic             par_err_sticky_q;
`endif

  // A stage may load if it is empty or everything downstream of it can move.
  // Folding from the output end keeps this a flat OR chain without a self-referencing vector.
  always_comb begin
    adv     = '0;
    adv_run = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv_run = adv_run | ~vld_q[i];
      adv[i]  = adv_run;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

`ifdef DFF_PIPE_PARITY_EN
  assign par_in = even_par(PAR_MAX_W'(in_data));
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_vld;
    logic [WIDTH-1:0] up_data;
    logic             s_vld;
    logic [WIDTH-1:0] s_data;
`ifdef DFF_PIPE_PARITY_EN
    logic             up_par;
    logic             s_par;
`endif

    if (i == 0) begin : g_head
      assign up_vld  = in_valid;
      assign up_data = in_data;
`ifdef DFF_PIPE_PARITY_EN
      assign up_par  = par_in;
`endif
    end else begin : g_body
      assign up_vld  = vld_q[i-1];
      assign up_data = data_q[i-1];
`ifdef DFF_PIPE_PARITY_EN
      assign up_par  = par_q[i-1];
`endif
    end

    dff_pipe_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .adv     (adv[i]),
      .up_vld  (up_vld),
      .up_data (up_data),
`ifdef DFF_PIPE_PARITY_EN
      .up_par  (up_par),
      .par     (s_par),
`endif
      .vld     (s_vld),
      .data    (s_data)
    );

    assign vld_q[i]  = s_vld;
    assign data_q[i] = s_data;
`ifdef DFF_PIPE_PARITY_EN
    assign par_q[i]  = s_par;
`endif
  end

  // Word count in flight always equals the number of valid stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q <= '0;
    end else if (clr) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
    end
  end

  assign occ = occ_q;

`ifdef DFF_PIPE_PARITY_EN
  assign par_err = out_valid & ((^out_data) != par_q[DEPTH-1]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_err_sticky_q <= 1'b0;
    end else if (clr) begin
      par_err_sticky_q <= 1'b0;
    end else if (par_err) begin
      par_err_sticky_q <= 1'b1;
    end
  end

  assign par_err_sticky = par_err_sticky_q;
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Scoreboard bench for dff_pipe: directed scenarios followed by randomized traffic.
// Parity scenario is compiled in only when DFF_PIPE_PARITY_EN is defined.
module tb_dff_pipe;

  localparam int         WIDTH   = 8;
  localparam int         DEPTH   = 4;
  localparam logic [7:0] RST_VAL = 8'hC3;
  localparam int         OCC_W   = $clog2(DEPTH + 1);

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic             clr       = 1'b0;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data   = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occ;
`ifdef DFF_PIPE_PARITY_EN
  logic             par_err;
  logic             par_err_sticky;
`endif

  int     checks   = 0;
  int     failures = 0;
  longint cyc      = 0;
  longint last_dep = -1000;
  bit     mon_en   = 1'b1;

  typedef struct {
    logic [WIDTH-1:0] data;
    longint           entry;
  } word_t;

  word_t q[$];

  dff_pipe #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .RST_VAL (RST_VAL)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .clr            (clr),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
`ifdef DFF_PIPE_PARITY_EN
    .par_err        (par_err),
    .par_err_sticky (par_err_sticky),
`endif
    .occ            (occ)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: each accepted word is visible at the output DEPTH cycles after acceptance,
  // or one cycle after its predecessor leaves, whichever is later. Words in flight == occ.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_occ", 64'(occ), 64'(0));
      chk("rst_out_data", 64'(out_data), 64'(RST_VAL));
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      q.delete();
      last_dep = -1000;
    end else if (mon_en) begin
      logic   exp_ov;
      longint rdy;
      exp_ov = 1'b0;
      if (q.size() > 0) begin
        rdy = q[0].entry + DEPTH;
        if (last_dep + 1 > rdy) rdy = last_dep + 1;
        exp_ov = (cyc >= rdy);
      end
      chk("sb_out_valid", 64'(out_valid), 64'(exp_ov));
      chk("sb_occ", 64'(occ), 64'(q.size()));
      chk("sb_in_ready", 64'(in_ready), 64'((q.size() < DEPTH) || out_ready));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("sb_unexpected_word", 64'(out_data), 64'(RST_VAL));
        end else begin
          chk("sb_out_data", 64'(out_data), 64'(q[0].data));
          void'(q.pop_front());
          last_dep = cyc;
        end
      end
      if (clr) q.delete();
      else if (in_valid && in_ready) q.push_back('{data: in_data, entry: cyc});
    end
  end

  task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit ordy, input bit c);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    clr       = c;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("in_ready_after_reset", 64'(in_ready), 64'(1));

    // streaming at full rate
    for (int k = 1; k <= 16; k++) drive(1'b1, 8'(k), 1'b1, 1'b0);
    drain(DEPTH + 2);

    // fill then stall, then pass-through on release
    for (int k = 0; k < 4; k++) drive(1'b1, 8'(8'hA0 + k), 1'b0, 1'b0);
    chk("fill_occ", 64'(occ), 64'(4));
    in_valid = 1'b1; in_data = 8'hA4; out_ready = 1'b0;
    #1 chk("fill_in_ready_low", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    chk("stall_occ_hold", 64'(occ), 64'(4));
    out_ready = 1'b1;
    #1;
    chk("passthru_in_ready", 64'(in_ready), 64'(1));
    chk("passthru_head", 64'(out_data), 64'(8'hA0));
    @(posedge clk); #1;
    chk("passthru_occ", 64'(occ), 64'(4));
    drive(1'b1, 8'hA5, 1'b1, 1'b0);
    drain(DEPTH + 2);

    // bubble collapse under stall
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    repeat (DEPTH - 1) drive(1'b0, '0, 1'b0, 1'b0);
    chk("bubble_out_valid", 64'(out_valid), 64'(1));
    chk("bubble_out_data", 64'(out_data), 64'(8'h55));
    drive(1'b1, 8'h66, 1'b0, 1'b0);
    chk("bubble_pack_occ", 64'(occ), 64'(2));
    repeat (DEPTH) drive(1'b0, '0, 1'b0, 1'b0);
    chk("bubble_pack_hold", 64'(occ), 64'(2));
    chk("bubble_head_kept", 64'(out_data), 64'(8'h55));
    drain(DEPTH + 2);

    // flush with a concurrent input that must be dropped
    for (int k = 0; k < 3; k++) drive(1'b1, 8'(8'h30 + k), 1'b0, 1'b0);
    chk("flush_pre_occ", 64'(occ), 64'(3));
    drive(1'b1, 8'h77, 1'b0, 1'b1);
    chk("flush_occ", 64'(occ), 64'(0));
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    drain(DEPTH + 2);

    // asynchronous reset with three words in flight
    for (int k = 0; k < 3; k++) drive(1'b1, 8'(8'h40 + k), 1'b0, 1'b0);
    chk("midrst_pre_occ", 64'(occ), 64'(3));
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_occ", 64'(occ), 64'(0));
    chk("midrst_out_data", 64'(out_data), 64'(RST_VAL));
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("midrst_in_ready", 64'(in_ready), 64'(1));
    drain(DEPTH + 2);

    // randomized traffic with varying consumer pressure
    for (int k = 0; k < 600; k++) begin
      bit v, r, c;
      int rd_pct;
      rd_pct = (k < 200) ? 90 : ((k < 400) ? 30 : 60);
      v = ($urandom_range(0, 99) < 70);
      r = ($urandom_range(0, 99) < rd_pct);
      c = ($urandom_range(0, 49) == 0);
      drive(v, 8'($urandom), r, c);
    end
    drain(DEPTH + 2);

`ifdef DFF_PIPE_PARITY_EN
    mon_en = 1'b0;
    drive(1'b1, 8'h3C, 1'b0, 1'b0);
    repeat (DEPTH - 1) drive(1'b0, '0, 1'b0, 1'b0);
    chk("par_clean", 64'(par_err), 64'(0));
    force u_dut.g_stage[DEPTH-1].u_stage.data = 8'h3D;
    #1 chk("par_err_set", 64'(par_err), 64'(1));
    @(posedge clk); #1;
    chk("par_sticky_set", 64'(par_err_sticky), 64'(1));
    release u_dut.g_stage[DEPTH-1].u_stage.data;
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("par_sticky_hold", 64'(par_err_sticky), 64'(1));
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("par_sticky_clr", 64'(par_err_sticky), 64'(0));
    chk("par_err_clr", 64'(par_err), 64'(0));
    q.delete();
    mon_en = 1'b1;
    drain(2);
`endif

    chk("sb_empty_at_end", 64'(q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
